fft_bfly_stage: RTL and testbench
=================================

// Module: fft_bfly_stage
// PURPOSE
//  Radix-2 DIF butterfly stage for the 64-point FFT; consumes the (x[n], x[n+32]) pairs from the input unit.
//  Each accepted pair produces y0 = a+b and y1 = (a-b)*W64^e through a 3-stage pipeline, tagged with valid/last.
//  Cascaded six times (STAGE=0..5) to form the full transform.
// PARAMETERS
//  STAGE  0  stage index 0..5; twiddle exponent e = (cnt mod (32>>STAGE)) << STAGE
//  SCALE  1  1: add/sub results arithmetic-shifted right by 1 (per-stage /2); 0: no scaling
//  DW     32 sample width, signed two's-complement Q16.16
// PORTS
//  clk         in  1   stage clock
//  rst         in  1   asynchronous, active-low reset
//  in_valid    in  1   a/b pair valid this cycle; no backpressure, a pair is accepted every valid cycle
//  a_re, a_im  in  DW  first butterfly input (x[n])
//  b_re, b_im  in  DW  second butterfly input (x[n+32])
//  out_valid   out 1   y0/y1 valid
//  out_last    out 1   high with the 32nd output pair of a frame
//  y0_re,y0_im out DW  sum output
//  y1_re,y1_im out DW  twiddled difference output
// BEHAVIOUR
//  - Reset (rst low, async): all pipeline registers, outputs and cnt cleared to 0 immediately. In-flight pairs are discarded.
//  - cnt: 5-bit pair counter, +1 per accepted pair, wraps 31->0. It is not advanced by idle cycles.
//  - P1 (cycle 1): s = a+b, d = a-b at DW+1 bits. SCALE=1: >>>1 then narrow to DW; SCALE=0: narrow (see SAT).
//    Register e from cnt, and last = (cnt==31).
//  - P2 (cycle 2): twiddle ROM lookup (wr, wi are 16-bit signed Q1.14, W = cos - j*sin).
//    Four 48-bit products dr*wr, di*wi, dr*wi, di*wr. s is delayed alongside.
//  - P3 (cycle 3): re = dr*wr - di*wi; im = dr*wi + di*wr (49 bits).
//    Add round constant 2^13, then >>>14, then narrow to DW. y0 = delayed s.
//  - Latency: exactly 3 clk from in_valid to out_valid. Back-to-back input gives back-to-back output.
//    out_valid is in_valid delayed 3 cycles; out_last is aligned to it.
//  - When out_valid=0, y0/y1 hold their last values.
//  - Twiddle e=0 gives W=16384+j0, so y1 is exactly d. Narrowing applies only where a result exceeds DW.
//  - A reset deasserted mid-frame restarts cnt at 0. The next accepted pair uses e=0.
// CONFIGURATION
//  FFT_BFLY_SAT_EN defined: every narrowing to DW saturates to 0x7FFFFFFF / 0x80000000 on overflow.
//  FFT_BFLY_SAT_EN undefined: narrowing keeps the low DW bits (two's-complement wrap). No extra logic.
// STRUCTURE
//  Package fft_pkg: DW, N=64, TW_W=16, TW_FRAC=14, the round constant, and the sat/narrow function.
//  Sub-module fft_twiddle_rom: 5-bit e in; registered 16-bit wr, wi out; 32-entry constant table; 1-cycle latency.
// TESTING
//  1 SCALE=0, STAGE=0, after reset: a=(0x00010000,0), b=(0x00010000,0)
//    -> 3 clk later y0=(0x00020000,0), y1=(0,0), out_valid=1.
//  2 STAGE=0: 16 dummy pairs, then a=(0x00010000,0), b=0 (e=16, W=-j)
//    -> y1=(0x00000000,0xFFFF0000).
//  3 32 back-to-back pairs
//    -> out_valid high for 32 consecutive cycles; out_last only on the 32nd; pair 33 uses e=0.
//  4 SCALE=0: a_re=b_re=0x7FFFFFFF
//    -> y0_re=0x7FFFFFFF with FFT_BFLY_SAT_EN; 0xFFFFFFFE without.
//  5 rst pulsed low mid-frame with pairs in flight
//    -> outputs 0 asynchronously, no stale out_valid; the next pair uses e=0.
//  6 in_valid toggling 1,0,1,0
//    -> out_valid pattern identical, 3 clk delayed; cnt advances only on valid.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// =============================================================================
// fft_pkg : widths, twiddle format, rounding constant and DW narrowing helper
// Rev 1.0
// =============================================================================
package fft_pkg;

  localparam int DW      = 32;
  localparam int N       = 64;
  localparam int TW_W    = 16;
  localparam int TW_FRAC = 14;
  localparam int CNT_W   = $clog2(N / 2);
  localparam int PROD_W  = DW + TW_W;
  localparam int ACC_W   = PROD_W + 1;

  localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(2 ** (TW_FRAC - 1));

`ifdef FFT_BFLY_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  // Every wide intermediate is funnelled through here on its way back to DW bits.
  function automatic logic [DW-1:0] narrow(input logic signed [ACC_W-1:0] x);
`ifdef FFT_BFLY_SAT_EN
    logic [DW-1:0] r;
    if (x > SAT_MAX) begin
      r = SAT_MAX[DW-1:0];
    end else if (x < SAT_MIN) begin
      r = SAT_MIN[DW-1:0];
    end else begin
      r = x[DW-1:0];
    end
    return r;
`else
    return x[DW-1:0];
`endif
  endfunction

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_twiddle_rom.sv
`default_nettype none
// =============================================================================
// fft_twiddle_rom : W64^e = cos - j*sin in Q1.14, registered output, 1-cycle latency
// Rev 1.0
// =============================================================================
module fft_twiddle_rom
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CNT_W-1:0]        e_i,
  output logic signed [TW_W-1:0]  wr_o,
  output logic signed [TW_W-1:0]  wi_o
);

  localparam logic signed [TW_W-1:0] WR_TAB [32] = '{
     16'sd16384,  16'sd16305,  16'sd16069,  16'sd15679,
     16'sd15137,  16'sd14449,  16'sd13623,  16'sd12665,
     16'sd11585,  16'sd10394,  16'sd9102,   16'sd7723,
     16'sd6270,   16'sd4756,   16'sd3196,   16'sd1606,
     16'sd0,     -16'sd1606,  -16'sd3196,  -16'sd4756,
    -16'sd6270,  -16'sd7723,  -16'sd9102,  -16'sd10394,
    -16'sd11585, -16'sd12665, -16'sd13623, -16'sd14449,
    -16'sd15137, -16'sd15679, -16'sd16069, -16'sd16305
  };

  // Imaginary part is -sin, so it is never positive over the half circle.
  localparam logic signed [TW_W-1:0] WI_TAB [32] = '{
     16'sd0,     -16'sd1606,  -16'sd3196,  -16'sd4756,
    -16'sd6270,  -16'sd7723,  -16'sd9102,  -16'sd10394,
    -16'sd11585, -16'sd12665, -16'sd13623, -16'sd14449,
    -16'sd15137, -16'sd15679, -16'sd16069, -16'sd16305,
    -16'sd16384, -16'sd16305, -16'sd16069, -16'sd15679,
    -16'sd15137, -16'sd14449, -16'sd13623, -16'sd12665,
    -16'sd11585, -16'sd10394, -16'sd9102,  -16'sd7723,
    -16'sd6270,  -16'sd4756,  -16'sd3196,  -16'sd1606
  };

  logic signed [TW_W-1:0] wr_q;
  logic signed [TW_W-1:0] wi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      wi_q <= '0;
    end else begin
      wr_q <= WR_TAB[e_i];
      wi_q <= WI_TAB[e_i];
    end
  end

  assign wr_o = wr_q;
  assign wi_o = wi_q;

endmodule : fft_twiddle_rom
`default_nettype wire

// File: rtl/fft_bfly_stage.sv
`default_nettype none
// =============================================================================
// fft_bfly_stage : radix-2 DIF butterfly, y0=a+b, y1=(a-b)*W64^e, 3-cycle pipeline
// Option FFT_BFLY_SAT_EN: saturate (instead of wrap) every narrowing to DW.  Rev 1.0
// =============================================================================
module fft_bfly_stage
  import fft_pkg::*;
#(
  parameter int STAGE = 0,
  parameter int SCALE = 1,
  parameter int DW    = fft_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  input  logic [DW-1:0] a_re_i,
  input  logic [DW-1:0] a_im_i,
  input  logic [DW-1:0] b_re_i,
  input  logic [DW-1:0] b_im_i,
  output logic          out_valid_o,
  output logic          out_last_o,
  output logic [DW-1:0] y0_re_o,
  output logic [DW-1:0] y0_im_o,
  output logic [DW-1:0] y1_re_o,
  output logic [DW-1:0] y1_im_o
);

  localparam logic [CNT_W-1:0] E_MASK = CNT_W'((32 >> STAGE) - 1);

  function automatic logic [DW-1:0] p1_out(input logic signed [DW:0] x);
    logic signed [DW:0] t;
    t = (SCALE != 0) ? (x >>> 1) : x;
    return narrow(ACC_W'(t));
  endfunction

  // ---------------------------------------------------------------- P1
  logic [CNT_W-1:0]   cnt_q, cnt_d, e_d;
  logic signed [DW:0] s_re_d, s_im_d, d_re_d, d_im_d;
  logic               v1_q, last1_q;
  logic [DW-1:0]      s_re1_q, s_im1_q, d_re1_q, d_im1_q;

  assign cnt_d  = in_valid_i ? cnt_q + CNT_W'(1) : cnt_q;
  assign e_d    = (cnt_q & E_MASK) << STAGE;
  assign s_re_d = $signed({a_re_i[DW-1], a_re_i}) + $signed({b_re_i[DW-1], b_re_i});
  assign s_im_d = $signed({a_im_i[DW-1], a_im_i}) + $signed({b_im_i[DW-1], b_im_i});
  assign d_re_d = $signed({a_re_i[DW-1], a_re_i}) - $signed({b_re_i[DW-1], b_re_i});
  assign d_im_d = $signed({a_im_i[DW-1], a_im_i}) - $signed({b_im_i[DW-1], b_im_i});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      s_re1_q <= '0;
      s_im1_q <= '0;
      d_re1_q <= '0;
      d_im1_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      v1_q    <= in_valid_i;
      last1_q <= in_valid_i && (cnt_q == '1);
      if (in_valid_i) begin
        s_re1_q <= p1_out(s_re_d);
        s_im1_q <= p1_out(s_im_d);
        d_re1_q <= p1_out(d_re_d);
        d_im1_q <= p1_out(d_im_d);
      end
    end
  end

  // The ROM is addressed from the live counter so its registered output lines
  // up with the P1 data, keeping the total latency at three cycles.
  logic signed [TW_W-1:0] wr_w, wi_w;

  fft_twiddle_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .e_i   (e_d),
    .wr_o  (wr_w),
    .wi_o  (wi_w)
  );

  // ---------------------------------------------------------------- P2
  logic                     v2_q, last2_q;
  logic [DW-1:0]            s_re2_q, s_im2_q;
  logic signed [PROD_W-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      s_re2_q <= '0;
      s_im2_q <= '0;
      p_rr_q  <= '0;
      p_ii_q  <= '0;
      p_ri_q  <= '0;
      p_ir_q  <= '0;
    end else begin
      v2_q    <= v1_q;
      last2_q <= last1_q;
      if (v1_q) begin
        s_re2_q <= s_re1_q;
        s_im2_q <= s_im1_q;
        p_rr_q  <= PROD_W'($signed(d_re1_q)) * PROD_W'(wr_w);
        p_ii_q  <= PROD_W'($signed(d_im1_q)) * PROD_W'(wi_w);
        p_ri_q  <= PROD_W'($signed(d_re1_q)) * PROD_W'(wi_w);
        p_ir_q  <= PROD_W'($signed(d_im1_q)) * PROD_W'(wr_w);
      end
    end
  end

  // ---------------------------------------------------------------- P3
  logic signed [ACC_W-1:0] re_acc_d, im_acc_d;

  assign re_acc_d = ACC_W'(p_rr_q) - ACC_W'(p_ii_q) + ROUND_C;
  assign im_acc_d = ACC_W'(p_ri_q) + ACC_W'(p_ir_q) + ROUND_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      y0_re_o     <= '0;
      y0_im_o     <= '0;
      y1_re_o     <= '0;
      y1_im_o     <= '0;
    end else begin
      out_valid_o <= v2_q;
      out_last_o  <= last2_q;
      if (v2_q) begin
        y0_re_o <= s_re2_q;
        y0_im_o <= s_im2_q;
        y1_re_o <= narrow(re_acc_d >>> TW_FRAC);
        y1_im_o <= narrow(im_acc_d >>> TW_FRAC);
      end
    end
  end

endmodule : fft_bfly_stage
`default_nettype wire

// File: tb/tb_fft_bfly_stage.sv
`default_nettype none
// =============================================================================
// tb_fft_bfly_stage : scoreboard bench, real-valued twiddle reference model
// Rev 1.0
// =============================================================================
module tb_fft_bfly_stage;

  localparam int  STAGE = 0;
  localparam int  SCALE = 0;
  localparam real PI    = 3.14159265358979323846;

  typedef struct {
    logic [31:0] y0r, y0i, y1r, y1i;
    logic        last;
    longint      cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic        out_valid, out_last;
  logic [31:0] y0_re, y0_im, y1_re, y1_im;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  int     mcnt = 0;
  exp_t   sb[$];
  exp_t   hold;

  fft_bfly_stage #(.STAGE(STAGE), .SCALE(SCALE), .DW(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .a_re_i      (a_re),
    .a_im_i      (a_im),
    .b_re_i      (b_re),
    .b_im_i      (b_im),
    .out_valid_o (out_valid),
    .out_last_o  (out_last),
    .y0_re_o     (y0_re),
    .y0_im_o     (y0_im),
    .y1_re_o     (y1_re),
    .y1_im_o     (y1_im)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference arithmetic on plain 64-bit integers and real trigonometry.
  function automatic longint to_dw(input longint x);
`ifdef FFT_BFLY_SAT_EN
    if (x > 64'sd2147483647)  return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
`else
    int t;
    t = int'(x);
    return longint'(t);
`endif
  endfunction

  function automatic longint sgn(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic exp_t model(input logic [31:0] ar, ai, br, bi, input int c, input longint cy);
    exp_t   r;
    longint sr, si, dr, di, wr, wi, yr, yi;
    int     e;
    real    ang;
    sr = sgn(ar) + sgn(br);
    si = sgn(ai) + sgn(bi);
    dr = sgn(ar) - sgn(br);
    di = sgn(ai) - sgn(bi);
    if (SCALE != 0) begin
      sr = sr >>> 1; si = si >>> 1; dr = dr >>> 1; di = di >>> 1;
    end
    sr = to_dw(sr); si = to_dw(si); dr = to_dw(dr); di = to_dw(di);
    e   = (c % (32 >> STAGE)) << STAGE;
    ang = 2.0 * PI * real'(e) / 64.0;
    wr  = longint'($rtoi($floor(16384.0 * $cos(ang) + 0.5)));
    wi  = longint'($rtoi($floor(-16384.0 * $sin(ang) + 0.5)));
    yr  = to_dw((dr * wr - di * wi + 8192) >>> 14);
    yi  = to_dw((dr * wi + di * wr + 8192) >>> 14);
    r.y0r = sr[31:0]; r.y0i = si[31:0];
    r.y1r = yr[31:0]; r.y1i = yi[31:0];
    r.last = (c == 31);
    r.cyc  = cy + 3;
    return r;
  endfunction

  task automatic send(input logic [31:0] ar, ai, br, bi);
    in_valid = 1'b1;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    sb.push_back(model(ar, ai, br, bi, mcnt, cyc));
    mcnt = (mcnt + 1) % 32;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      a_re = $urandom(); a_im = $urandom(); b_re = $urandom(); b_im = $urandom();
      @(posedge clk); #1;
    end
  endtask

  task automatic send_rand();
    send($urandom(), $urandom(), $urandom(), $urandom());
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, longint'(out_valid), 0);
    chk({tag, "_last"},  longint'(out_last),  0);
    chk({tag, "_y0re"},  longint'(y0_re), 0);
    chk({tag, "_y0im"},  longint'(y0_im), 0);
    chk({tag, "_y1re"},  longint'(y1_re), 0);
    chk({tag, "_y1im"},  longint'(y1_im), 0);
  endtask

  // Monitor: pops one expectation per presented output; otherwise checks hold.
  always @(negedge clk) begin : mon
    exp_t x;
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          x = sb.pop_front();
          chk("latency", cyc, x.cyc);
          chk("out_last", longint'(out_last), longint'(x.last));
          chk("y0_re", longint'(y0_re), longint'(x.y0r));
          chk("y0_im", longint'(y0_im), longint'(x.y0i));
          chk("y1_re", longint'(y1_re), longint'(x.y1r));
          chk("y1_im", longint'(y1_im), longint'(x.y1i));
          hold = x;
        end
      end else begin
        chk("idle_last", longint'(out_last), 0);
        chk("hold_y0_re", longint'(y0_re), longint'(hold.y0r));
        chk("hold_y1_im", longint'(y1_im), longint'(hold.y1i));
      end
    end
  end

  initial begin
    hold = '{y0r: '0, y0i: '0, y1r: '0, y1i: '0, last: 1'b0, cyc: 0};
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // Frame 1: unit pair at e=0, randoms, unit pair at e=16 (W=-j), randoms.
    send(32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0);
    repeat (15) send_rand();
    send(32'h0001_0000, 32'h0, 32'h0, 32'h0);
    repeat (15) send_rand();
    // 33rd pair wraps the counter back to e=0.
    send(32'h0, 32'h0001_0000, 32'h0, 32'h0);
    idle(2);

    // Overflow corners in both sum and difference paths.
    send(32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF, 32'h0);
    send(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    send(32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF);
    send(32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000);
    idle(1);

    // Valid toggling 1,0,1,0 then random gaps.
    for (int i = 0; i < 12; i++) begin
      send_rand();
      idle(1);
    end
    for (int i = 0; i < 40; i++) begin
      send_rand();
      idle($urandom_range(0, 2));
    end

    // Asynchronous reset mid-frame with pairs still in the pipeline.
    repeat (5) send_rand();
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    sb.delete();
    mcnt = 0;
    hold = '{y0r: '0, y0i: '0, y1r: '0, y1i: '0, last: 1'b0, cyc: 0};
    #1;
    chk_zero("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(32'h0001_0000, 32'h0000_4000, 32'h0, 32'h0001_0000);
    repeat (35) send_rand();

    idle(1);
    for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
    chk("drain_queue_empty", longint'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_fft_bfly_stage
`default_nettype wire
